// File: rtl/ternary_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : ternary_frame_engine
// Brief    : Strided SRAM frame sequencer with PT-5 trit decode and per-lane
//            saturating ternary MAC.
// Revision : 1.0
// ============================================================================
module ternary_frame_engine #(
  parameter int BYTES_PER_WORD = 3,
  parameter int ACC_WIDTH      = 32,
  parameter int SRAM_AW        = 12,
  parameter int RD_LAT         = 1
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      start,
  input  logic [SRAM_AW-1:0]                        base_addr,
  input  logic [15:0]                               depth,
  input  logic [7:0]                                stride,
  input  logic [1:0]                                op_mode,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      mode_err,
  output logic                                      decode_err,
  output logic                                      sat,
  output logic                                      mem_rd_en,
  output logic [SRAM_AW-1:0]                        mem_addr,
  input  logic [8*BYTES_PER_WORD-1:0]               weight_word,
  input  logic [8*BYTES_PER_WORD-1:0]               input_word,
  output logic [5*BYTES_PER_WORD*ACC_WIDTH-1:0]     vector_results
);

  localparam int c_LANES = 5 * BYTES_PER_WORD;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [1:0] c_MAC_CLR = 2'd0;
  localparam logic [1:0] c_ELEM    = 2'd2;
  localparam logic [1:0] c_RSVD    = 2'd3;

  localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] c_ACC_ONE  = ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] c_ACC_NEG1 = {ACC_WIDTH{1'b1}};

  // Returns {neg, pos} for base-3 digit k of a byte (digit 1 -> +1, 2 -> -1).
  function automatic logic [1:0] pt5_trit(input logic [7:0] b, input int k);
    logic [7:0] q;
    logic [7:0] d;
    q = b;
    for (int i = 0; i < k; i++) q = q / 8'd3;
    d = q % 8'd3;
    return {d == 8'd2, d == 8'd1};
  endfunction

  logic [1:0]           r_state;
  logic [SRAM_AW-1:0]   r_addr;
  logic [15:0]          r_left;
  logic [7:0]           r_stride;
  logic [1:0]           r_mode;
  logic [RD_LAT-1:0]    r_vld;
  logic                 r_mode_err;
  logic                 r_decode_err;
  logic                 r_sat;

  logic                 w_rd;
  logic                 w_upd;
  logic                 w_clr;
  logic [RD_LAT-1:0]    w_vld_next;
  logic [BYTES_PER_WORD-1:0] w_bad;
  logic [c_LANES-1:0]   w_sat_hit;

  assign w_rd  = (r_state == c_ISSUE);
  assign w_upd = r_vld[RD_LAT-1];
  assign w_clr = (r_state == c_IDLE) && start && (op_mode == c_MAC_CLR);

  generate
    if (RD_LAT == 1) begin : g_vld_one
      assign w_vld_next = w_rd;
    end else begin : g_vld_multi
      assign w_vld_next = {r_vld[RD_LAT-2:0], w_rd};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_IDLE;
      r_addr       <= '0;
      r_left       <= '0;
      r_stride     <= '0;
      r_mode       <= '0;
      r_vld        <= '0;
      r_mode_err   <= 1'b0;
      r_decode_err <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_vld <= w_vld_next;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if (op_mode == c_RSVD) begin
              r_mode_err <= 1'b1;
            end else begin
              r_addr       <= base_addr;
              r_left       <= depth;
              r_stride     <= stride;
              r_mode       <= op_mode;
              r_mode_err   <= 1'b0;
              r_decode_err <= 1'b0;
              r_sat        <= 1'b0;
              r_state      <= (depth == 16'd0) ? c_DONE : c_ISSUE;
            end
          end
        end
        c_ISSUE: begin
          r_addr <= r_addr + SRAM_AW'(r_stride);
          r_left <= r_left - 16'd1;
          if (r_left == 16'd1) r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          if (w_vld_next == '0) r_state <= c_DONE;
        end
        default: r_state <= c_IDLE;
      endcase
      // Pipeline is always empty in IDLE, so these never race the clear above.
      if (w_upd && (|w_bad))     r_decode_err <= 1'b1;
      if (w_upd && (|w_sat_hit)) r_sat        <= 1'b1;
    end
  end

  generate
    for (genvar j = 0; j < BYTES_PER_WORD; j++) begin : g_byte
      logic [7:0] w_wb;
      logic [7:0] w_xb;
      assign w_wb     = weight_word[j*8 +: 8];
      assign w_xb     = input_word[j*8 +: 8];
      assign w_bad[j] = (w_wb > 8'd242) || (w_xb > 8'd242);

      for (genvar k = 0; k < 5; k++) begin : g_trit
        logic [1:0]                  w_wt;
        logic [1:0]                  w_xt;
        logic                        w_p_pos;
        logic                        w_p_neg;
        logic signed [ACC_WIDTH-1:0] r_acc;

        assign w_wt    = (w_wb > 8'd242) ? 2'b00 : pt5_trit(w_wb, k);
        assign w_xt    = (w_xb > 8'd242) ? 2'b00 : pt5_trit(w_xb, k);
        assign w_p_pos = (w_wt[0] & w_xt[0]) | (w_wt[1] & w_xt[1]);
        assign w_p_neg = (w_wt[0] & w_xt[1]) | (w_wt[1] & w_xt[0]);
        assign w_sat_hit[j*5+k] = (r_mode != c_ELEM) &&
                                  ((w_p_pos && r_acc == c_ACC_MAX) ||
                                   (w_p_neg && r_acc == c_ACC_MIN));

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_acc <= '0;
          end else if (w_clr) begin
            r_acc <= '0;
          end else if (w_upd) begin
            if (r_mode == c_ELEM)
              r_acc <= w_p_pos ? c_ACC_ONE : (w_p_neg ? c_ACC_NEG1 : '0);
            else if (!w_sat_hit[j*5+k] && w_p_pos)
              r_acc <= r_acc + c_ACC_ONE;
            else if (!w_sat_hit[j*5+k] && w_p_neg)
              r_acc <= r_acc + c_ACC_NEG1;
          end
        end

        assign vector_results[(j*5+k)*ACC_WIDTH +: ACC_WIDTH] = r_acc;
      end
    end
  endgenerate

  assign busy       = (r_state != c_IDLE);
  assign done       = (r_state == c_DONE);
  assign mem_rd_en  = w_rd;
  assign mem_addr   = r_addr;
  assign mode_err   = r_mode_err;
  assign decode_err = r_decode_err;
  assign sat        = r_sat;

endmodule
`default_nettype wire

// File: doc/ternary_frame_engine.md
Name: ternary_frame_engine

Overview:
Parametrised successor to the fixed 15-lane fabric datapath. It sequences strided frame reads from an external dual-bank weight/input SRAM with configurable read latency, and decodes PT-5 packed bytes into trits. It runs a per-lane ternary MAC in one of three modes, with saturating accumulators and sticky error flags. It sits between the AXI control plane (config/start/done) and the SRAM banks, and replaces the separate frame controller, unpacker and vector engine.

Parameters:
BYTES_PER_WORD, 3, packed bytes per SRAM word; LANES = 5*BYTES_PER_WORD
ACC_WIDTH, 32, signed accumulator width per lane (>=4)
SRAM_AW, 12, SRAM address width
RD_LAT, 1, SRAM read latency in cycles (1..4)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  start request; sampled only in IDLE
base_addr  in  SRAM_AW  first frame address
depth  in  16  number of words per frame
stride  in  8  address increment per word
op_mode  in  2  0=MAC_CLR, 1=MAC_ACC, 2=ELEM (last product), 3=reserved
busy  out  1  frame in progress
done  out  1  one-cycle completion pulse
mode_err  out  1  sticky: start with op_mode=3
decode_err  out  1  sticky: any decoded byte >242
sat  out  1  sticky: any lane saturated
mem_rd_en  out  1  read strobe to both banks
mem_addr  out  SRAM_AW  shared read address
weight_word  in  8*BYTES_PER_WORD  weight bank data
input_word  in  8*BYTES_PER_WORD  input bank data
vector_results  out  LANES*ACC_WIDTH  lane L at bits [L*ACC_WIDTH +: ACC_WIDTH]

Behaviour:
- Reset (async, reset_n=0): all outputs 0, accumulators 0, FSM IDLE, read-valid pipeline empty, sticky flags clear. Reset mid-frame aborts immediately. Frame restarts only on a new start.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- Start accept: start=1 in IDLE at edge 0 latches base/depth/stride/op_mode.
  - op_mode=3: set mode_err, stay IDLE, no done.
  - MAC_CLR: clears accumulators on the accept edge.
- busy=1 from cycle 1 through the DONE cycle inclusive. start while not IDLE is ignored.
- ISSUE: one read per cycle, mem_rd_en=1, mem_addr = base + i*stride mod 2^SRAM_AW, i=0..depth-1, in cycles 1..depth.
- Read-valid shift register, RD_LAT deep: data for read i is sampled RD_LAT cycles after issue; accumulators update on that edge.
- DRAIN waits until the pipeline is empty. DONE asserts done=1 for exactly one cycle, at cycle depth+RD_LAT+1.
- depth=0: no reads; DONE in cycle 1; in MAC_CLR the results are still cleared.
- PT-5 decode:
  - Byte j = word bits [j*8 +: 8].
  - Digit k = (byte/3^k) mod 3, k=0..4; digit 0->0, 1->+1, 2->-1. Trit k of byte j drives lane j*5+k.
  - Byte >242: all five trits forced to 0 and decode_err set.
- Per-lane product p = w*x in {-1,0,+1}.
  - MAC_CLR/MAC_ACC: acc += p, saturating at +(2^(ACC_WIDTH-1)-1) / -(2^(ACC_WIDTH-1)). Saturation sets sat; acc holds at the limit.
  - ELEM: acc = p (no saturation possible).
- Sticky flags clear on a successful start accept (op_mode!=3) and on reset.
- vector_results is a direct view of the registered accumulators. It is stable outside ISSUE/DRAIN.

Test Plan:
1. Basic MAC: RD_LAT=1, MAC_CLR, base=0x010, stride=2, depth=4, all weight/input bytes 0x79 (all +1) -> mem_addr 0x010,0x012,0x014,0x016 in cycles 1-4; done pulse in cycle 6; every lane =4; busy low cycle 7.
2. Continue and sign: repeat test 1 in MAC_ACC with input bytes 0xF2 (all -1) -> every lane 0. Then ELEM with weight 0x79 and input 0x79 -> every lane 1.
3. Decode error and latency: RD_LAT=3, depth=2, weight byte0=0xF3 in read 0 -> lanes 0-4 receive 0 from read 0 and decode_err=1; done in cycle 6. A later clean start clears decode_err.
4. Saturation and wrap: ACC_WIDTH=4, SRAM_AW=12, base=0xFFE, stride=1, depth=10, all +1 -> addresses 0xFFE,0xFFF,0x000,...; lanes end at 7; sat=1.
5. Control corners:
   - depth=0 MAC_CLR after test 1 -> lanes 0, done in cycle 1, no mem_rd_en.
   - start pulses during ISSUE -> ignored.
   - op_mode=3 -> mode_err=1, busy stays 0.
6. Reset mid-frame: reset_n=0 during ISSUE cycle 2 of test 1 -> all outputs 0 immediately. After release, a new start re-runs cleanly with lanes =4.
